// File: rtl/tiny16_pkg.sv
// Shared types and constants for the tiny16 boot loader: loader FSM states and frame constants.
package tiny16_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    CNT_H,
    CNT_L,
    DATA_H,
    DATA_L,
    CSUM,
    DONE,
    ERR
  } ld_state_e;

  // States in which a frame is open and the idle timeout applies.
  function automatic logic in_frame(input ld_state_e s);
    return (s inside {ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CSUM});
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter for the loader; expired latches once TIMEOUT enabled cycles pass without a clear.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // TIMEOUT of zero never sets expired, so the counter simply parks.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      if (count == CW'(TIMEOUT - 1)) begin
        expired <= (TIMEOUT != 0);
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Boot-time loader: parses a framed byte stream into big-endian 16-bit words and writes them
// through the memory write port, checking an XOR checksum and reporting done/err.
module mem_loader
  import tiny16_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              mem_in_en,
  output logic [WORD_W-1:0] mem_in_addr,
  output logic [WORD_W-1:0] mem_in_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] words_written
);

  ld_state_e         state;
  ld_state_e         state_next;
  logic [WORD_W-1:0] cur_addr;
  logic [WORD_W-1:0] remaining;
  logic [BYTE_W-1:0] hi_byte;
  logic [BYTE_W-1:0] csum;
  logic              acc_c;
  logic              wr_c;
  logic              frame_c;
  logic              expired;

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_c || !frame_c),
    .enable (frame_c),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; an accepted byte in the same cycle takes priority over a timeout.
  always_comb begin
    state_next = state;
    acc_c      = rx_valid && rx_ready;
    frame_c    = in_frame(state);
    wr_c       = acc_c && (state == DATA_L);
    case (state)
      IDLE:   if (acc_c && rx_data == SYNC_BYTE) state_next = ADDR_H;
      ADDR_H: if (acc_c) state_next = ADDR_L;
      ADDR_L: if (acc_c) state_next = CNT_H;
      CNT_H:  if (acc_c) state_next = CNT_L;
      CNT_L:  if (acc_c) state_next = ({remaining[15:8], rx_data} != '0) ? DATA_H : CSUM;
      DATA_H: if (acc_c) state_next = DATA_L;
      DATA_L: if (acc_c) state_next = (remaining != WORD_W'(1)) ? DATA_H : CSUM;
      CSUM:   if (acc_c) state_next = (rx_data == csum) ? DONE : ERR;
      DONE:   state_next = IDLE;
      ERR:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (frame_c && !acc_c && expired) state_next = ERR;
  end

  // Status outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_ready      <= 1'b0;
      mem_in_en     <= 1'b0;
      mem_in_addr   <= '0;
      mem_in_data   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
      cur_addr      <= '0;
      remaining     <= '0;
      hi_byte       <= '0;
      csum          <= '0;
    end else begin
      rx_ready  <= !(state_next inside {DONE, ERR});
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      err       <= (state_next == ERR);
      mem_in_en <= wr_c;
      if (acc_c) begin
        if (frame_c && state != CSUM) csum <= csum ^ rx_data;
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              words_written <= '0;
              csum          <= '0;
            end
          end
          ADDR_H: cur_addr[15:8]  <= rx_data;
          ADDR_L: cur_addr[7:0]   <= rx_data;
          CNT_H:  remaining[15:8] <= rx_data;
          CNT_L:  remaining[7:0]  <= rx_data;
          DATA_H: hi_byte         <= rx_data;
          DATA_L: begin
            mem_in_addr <= cur_addr;
            mem_in_data <= {hi_byte, rx_data};
            cur_addr    <= cur_addr + WORD_W'(1);
            remaining   <= remaining - WORD_W'(1);
            if (words_written != 16'hFFFF) words_written <= words_written + WORD_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes and done/err events are queued by the
// stimulus and consumed by a negedge monitor; memory contents are read back afterwards.
module tb_mem_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        mem_in_en;
  logic [15:0] mem_in_addr;
  logic [15:0] mem_in_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  logic [15:0] mem [0:65535];
  logic        out_en = 1'b0;
  logic [15:0] out_addr = 16'h0000;
  logic [15:0] out_data;

  int n_vec  = 0;
  int n_miss = 0;

  wr_t exp_wr[$];
  int  exp_ev[$];

  mem_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_in_en    (mem_in_en),
    .mem_in_addr  (mem_in_addr),
    .mem_in_data  (mem_in_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Behavioural 64Kx16 memory: write on the falling edge, registered read port.
  always @(negedge clk) if (mem_in_en) mem[mem_in_addr] <= mem_in_data;
  always @(posedge clk) if (out_en) out_data <= mem[out_addr];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every write strobe and every done/err pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst && mem_in_en) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write_addr", mem_in_addr, 16'hXXXX);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("write_addr", mem_in_addr, w.a);
        check("write_data", mem_in_data, w.d);
      end
    end
    if (rst && done && err) check("done_and_err", 16'd1, 16'd0);
    if (rst && (done || err)) begin
      logic [15:0] code;
      code = done ? 16'd1 : 16'd2;
      if (exp_ev.size() == 0) check("unexpected_event", code, 16'd0);
      else check("event", code, 16'(exp_ev.pop_front()));
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("rx_ready_timeout", 16'd0, 16'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_all(input logic [7:0] f[$]);
    foreach (f[i]) send(f[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("busy_stuck", 16'd1, 16'd0);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    out_en   = 1'b1;
    out_addr = a;
    @(posedge clk); #1;
    d      = out_data;
    out_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 16'(rx_ready), 16'd0);
    check({tag, "_mem_in_en"}, 16'(mem_in_en), 16'd0);
    check({tag, "_mem_in_addr"}, mem_in_addr, 16'h0000);
    check({tag, "_mem_in_data"}, mem_in_data, 16'h0000);
    check({tag, "_busy"}, 16'(busy), 16'd0);
    check({tag, "_done"}, 16'(done), 16'd0);
    check({tag, "_err"}, 16'(err), 16'd0);
    check({tag, "_words_written"}, words_written, 16'h0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    int          cyc;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'hDEAD;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check("rx_ready_after_reset", 16'(rx_ready), 16'd1);

    // 1: two words, good checksum (01^00^00^02^12^34^AB^CD = 43)
    exp_wr.push_back('{16'h0100, 16'h1234});
    exp_wr.push_back('{16'h0101, 16'hABCD});
    exp_ev.push_back(1);
    send_all('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43});
    check("t1_busy_in_done", 16'(busy), 16'd1);
    check("t1_rx_ready_in_done", 16'(rx_ready), 16'd0);
    wait_idle();
    check("t1_words_written", words_written, 16'd2);
    rd(16'h0100, d); check("t1_mem_0100", d, 16'h1234);
    rd(16'h0101, d); check("t1_mem_0101", d, 16'hABCD);

    // 2: same frame, checksum flipped -> writes still happen, err
    mem[16'h0100] = 16'h0000;
    mem[16'h0101] = 16'h0000;
    exp_wr.push_back('{16'h0100, 16'h1234});
    exp_wr.push_back('{16'h0101, 16'hABCD});
    exp_ev.push_back(2);
    send_all('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBC});
    wait_idle();
    check("t2_words_written", words_written, 16'd2);
    rd(16'h0100, d); check("t2_mem_0100", d, 16'h1234);
    rd(16'h0101, d); check("t2_mem_0101", d, 16'hABCD);

    // 3: leading junk dropped, address wraps FFFF -> 0000 (csum = 02)
    exp_wr.push_back('{16'hFFFF, 16'h1111});
    exp_wr.push_back('{16'h0000, 16'h2222});
    exp_ev.push_back(1);
    send_all('{8'h00, 8'hFF, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02,
               8'h11, 8'h11, 8'h22, 8'h22, 8'h02});
    wait_idle();
    check("t3_words_written", words_written, 16'd2);
    rd(16'hFFFF, d); check("t3_mem_ffff", d, 16'h1111);
    rd(16'h0000, d); check("t3_mem_0000", d, 16'h2222);

    // 4: zero-count frame, no writes
    exp_ev.push_back(1);
    send_all('{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20});
    wait_idle();
    check("t4_words_written", words_written, 16'd0);

    // 5: timeout with a partial word pending
    exp_ev.push_back(2);
    send_all('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h56});
    cyc = 0;
    while (!err && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (cyc < 16 || cyc > 18) begin
      n_miss++;
      $display("FAIL t5_timeout_latency: got %0d cycles expected 16..18", cyc);
    end
    wait_idle();
    check("t5_words_written", words_written, 16'd0);
    rd(16'h0010, d); check("t5_mem_0010", d, 16'hDEAD);

    // 6: reset after DATA_H abandons the frame; a fresh frame then loads
    send_all('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h12});
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("t6_reset");
    rst = 1'b1;
    @(posedge clk); #1;
    exp_wr.push_back('{16'h0300, 16'hBEEF});
    exp_ev.push_back(1);
    send_all('{8'hA5, 8'h03, 8'h00, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h53});
    wait_idle();
    check("t6_words_written", words_written, 16'd1);
    rd(16'h0300, d); check("t6_mem_0300", d, 16'hBEEF);

    repeat (4) @(posedge clk);
    #1;
    check("pending_writes", 16'(exp_wr.size()), 16'd0);
    check("pending_events", 16'(exp_ev.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
